// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU instruction issuer.
// Opcodes, FSM states and instruction field positions.
package alu_issue_pkg;

  localparam int INSTR_W = 18;
  localparam int OP_W    = 3;
  localparam int REG_W   = 5;

  localparam int OP_MSB = 17;
  localparam int OP_LSB = 15;
  localparam int RW_MSB = 14;
  localparam int RW_LSB = 10;
  localparam int RA_MSB = 9;
  localparam int RA_LSB = 5;
  localparam int RB_MSB = 4;
  localparam int RB_LSB = 0;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_MUL = 3'd2;
  localparam logic [OP_W-1:0] OP_DIV = 3'd3;
  localparam logic [OP_W-1:0] OP_MOD = 3'd4;
  localparam logic [OP_W-1:0] OP_AND = 3'd5;
  localparam logic [OP_W-1:0] OP_OR  = 3'd6;
  localparam logic [OP_W-1:0] OP_XOR = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_instr_decode.sv
// Splits a packed instruction into its fields.
// Also flags div/mod opcodes for the zero-divisor check.
module alu_instr_decode
  import alu_issue_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic [OP_W-1:0]    op,
  output logic [REG_W-1:0]   rw,
  output logic [REG_W-1:0]   ra,
  output logic [REG_W-1:0]   rb,
  output logic               is_divmod
);

  assign op = instr[OP_MSB:OP_LSB];
  assign rw = instr[RW_MSB:RW_LSB];
  assign ra = instr[RA_MSB:RA_LSB];
  assign rb = instr[RB_MSB:RB_LSB];

  always_comb begin
    is_divmod = 1'b0;
    unique case (1'b1)
      (op == OP_DIV): is_divmod = 1'b1;
      (op == OP_MOD): is_divmod = 1'b1;
      default:        is_divmod = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one 3-operand instruction at a time into the
// register file + ALU datapath and returns the result.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic [REG_W-1:0]   RA,
  output logic [REG_W-1:0]   RB,
  output logic [REG_W-1:0]   RW,
  output logic [OP_W-1:0]    s,
  output logic               we,
  input  logic [31:0]        A,
  input  logic [31:0]        B,
  input  logic [31:0]        W,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_result,
  output logic [REG_W-1:0]   out_rw,
  output logic               out_err,
  output logic [CNT_W-1:0]   issue_count
);

  state_t           state;
  logic [OP_W-1:0]  d_op;
  logic [REG_W-1:0] d_rw;
  logic [REG_W-1:0] d_ra;
  logic [REG_W-1:0] d_rb;
  logic             d_divmod;
  logic             divmod_q;
  logic             err;
  logic             unused_a;

  alu_instr_decode u_dec (
    .instr     (in_instr),
    .op        (d_op),
    .rw        (d_rw),
    .ra        (d_ra),
    .rb        (d_rb),
    .is_divmod (d_divmod)
  );

  // Read data A only feeds the ALU; the issuer never inspects it.
  assign unused_a = ^A;

  assign in_ready = (state == ST_IDLE);
  assign err      = divmod_q && (B == 32'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      RA          <= '0;
      RB          <= '0;
      RW          <= '0;
      s           <= '0;
      divmod_q    <= 1'b0;
      we          <= 1'b0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_rw      <= '0;
      out_err     <= 1'b0;
      issue_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            RA       <= d_ra;
            RB       <= d_rb;
            RW       <= d_rw;
            s        <= d_op;
            divmod_q <= d_divmod;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          out_result <= err ? 32'd0 : W;
          out_rw     <= RW;
          out_err    <= err;
          we         <= !err;
          state      <= ST_WRITE;
        end
        ST_WRITE: begin
          we        <= 1'b0;
          out_valid <= 1'b1;
          if (!out_err)
            issue_count <= issue_count + CNT_W'(1);
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
